// File: rtl/sun_apb_master.sv
// APB initiator: buffers write/read commands in a FIFO and issues them as
// SETUP/ACCESS transfers, completing on ready, a fixed read window, or timeout.
module sun_apb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int READ_FIXED = 1
) (
  input  logic        pclk,
  input  logic        presets,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psels,
  output logic        penables,
  output logic        pwrites,
  output logic [31:0] paddrs,
  output logic [31:0] pwdatas,
  input  logic [31:0] prdatas,
  input  logic        preadys
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  logic [64:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          full_s, push_s, pop_s, done_s, fixed_read_s;
  logic [64:0]   head_s;

  assign full_s       = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push_s       = cmd_valid & ~full_s;
  assign head_s       = mem_q[rd_ptr_q];
  assign fixed_read_s = (READ_FIXED != 0) && !pwrite_q;

  // Next-state, bus-phase and completion decode
  always_comb begin
    pop_s       = 1'b0;
    done_s      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (count_q != '0) begin
          pop_s   = 1'b1;
          psel_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 8'd0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (!fixed_read_s && preadys) begin
          done_s      = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'd0 : prdatas;
          rsp_err_d   = 1'b0;
        end else if (fixed_read_s && (cnt_q == 8'd1)) begin
          done_s      = 1'b1;
          rsp_rdata_d = prdatas;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          done_s      = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
        end else begin
          done_s = 1'b0;
        end
        // A queued command chains straight into SETUP without an idle cycle
        if (done_s) begin
          rsp_valid_d = 1'b1;
          penable_d   = 1'b0;
          if (count_q != '0) begin
            pop_s   = 1'b1;
            state_d = ST_SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
    pwrite_d = pop_s ? head_s[64]    : pwrite_q;
    paddr_d  = pop_s ? head_s[63:32] : paddr_q;
    pwdata_d = pop_s ? head_s[31:0]  : pwdata_q;
    count_d  = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
  end

  // Command storage; contents need no reset since count_q gates every read
  always_ff @(posedge pclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge pclk) begin
    if (presets) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cnt_q       <= 8'd0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'd0;
      pwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q    <= pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = ~full_s;
  assign psels     = psel_q;
  assign penables  = penable_q;
  assign pwrites   = pwrite_q;
  assign paddrs    = paddr_q;
  assign pwdatas   = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sun_apb_master.sv
// Bench for sun_apb_master: table vectors, directed corner sequences and random
// traffic against a transaction-level expectation model and a sun-sensor responder.
module tb_sun_apb_master;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int READ_FIXED = 1;

  logic        pclk = 1'b0;
  logic        presets = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psels, penables, pwrites;
  logic [31:0] paddrs, pwdatas;
  logic [31:0] prdatas = 32'd0;
  logic        preadys = 1'b0;

  always #5 pclk = ~pclk;

  sun_apb_master #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT), .READ_FIXED(READ_FIXED)) dut (
    .pclk(pclk), .presets(presets),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psels(psels), .penables(penables), .pwrites(pwrites),
    .paddrs(paddrs), .pwdatas(pwdatas), .prdatas(prdatas), .preadys(preadys)
  );

  // Sun-sensor register model: 0x00 bit0 enable, 0x01 threshold, 0x02 sample count,
  // 0x04 sample input (sums samples above threshold), 0x06 reads the sum.
  typedef struct packed {
    logic [15:0][31:0] regs;
    logic [31:0]       acc;
    logic [31:0]       taken;
  } sensor_t;

  typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } cmd_t;
  typedef struct packed { logic err; logic [31:0] rdata; logic [31:0] len; } exp_t;
  typedef struct {
    logic w; logic [31:0] a; logic [31:0] d; int r;
    logic err; logic [31:0] rdata; int len;
  } vec_t;

  function automatic sensor_t sensor_wr(sensor_t s, logic [31:0] a, logic [31:0] d);
    sensor_t n = s;
    if (a == 32'd4) begin
      if (n.regs[0][0] && (n.taken < n.regs[2])) begin
        if (d > n.regs[1]) n.acc = n.acc + d;
        n.taken = n.taken + 32'd1;
      end
    end else if (a < 32'd16) begin
      n.regs[a[3:0]] = d;
    end
    return n;
  endfunction

  function automatic logic [31:0] sensor_rd(sensor_t s, logic [31:0] a);
    if (a == 32'd6) return s.acc;
    else if (a < 32'd16) return s.regs[a[3:0]];
    else return a ^ 32'hA5A5_0000;
  endfunction

  cmd_t    iss_q[$];
  int      plan_q[$];
  exp_t    exp_q[$];
  sensor_t sens = '0;
  sensor_t ref_s = '0;
  cmd_t    cur = '0;
  int      vectors = 0;
  int      miscompares = 0;
  int      acc_idx = 0;
  int      cur_ready = 0;
  int      last_len = 0;
  int      cmd_ready_at = 0;
  logic    last_accept = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: responder, expectation bookkeeping and per-cycle checks.
  task automatic tick();
    logic acc_pre, accept, commit, rst_pre;
    int   idx_pre;
    cmd_t c;
    exp_t e;
    logic [31:0] wa, wd;
    rst_pre = presets;
    acc_pre = psels && penables;
    idx_pre = acc_idx;
    accept  = cmd_valid && cmd_ready && !presets;
    commit  = acc_pre && preadys && pwrites && !presets;
    wa = paddrs;
    wd = pwdatas;
    c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
    @(posedge pclk);
    #1;
    last_accept = accept;
    if (commit) sens = sensor_wr(sens, wa, wd);
    if (rst_pre) begin
      iss_q.delete(); plan_q.delete(); exp_q.delete();
      ref_s = sens;
      cur_ready = 0;
      chk("rst_psels", {31'd0, psels}, 32'd0);
      chk("rst_penables", {31'd0, penables}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end else begin
      if (accept) begin
        iss_q.push_back(c);
        plan_q.push_back(cmd_ready_at);
        e.rdata = 32'd0;
        if (c.w || READ_FIXED == 0) begin
          if (cmd_ready_at >= 1 && cmd_ready_at <= TIMEOUT) begin
            e.err = 1'b0; e.len = 32'(cmd_ready_at);
            if (c.w) ref_s = sensor_wr(ref_s, c.a, c.d);
            else e.rdata = sensor_rd(ref_s, c.a);
          end else begin
            e.err = 1'b1; e.len = 32'(TIMEOUT);
          end
        end else begin
          e.err = 1'b0; e.len = 32'd2; e.rdata = sensor_rd(ref_s, c.a);
        end
        exp_q.push_back(e);
      end
      chk("rsp_timing", {31'd0, rsp_valid}, {31'd0, acc_pre && !(psels && penables)});
      if (rsp_valid) begin
        last_len = idx_pre;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("access_len", 32'(idx_pre), e.len);
        end
      end
      if (psels && !penables) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", 32'd1, 32'd0);
        end else begin
          cur = iss_q.pop_front();
          cur_ready = plan_q.pop_front();
        end
      end
      if (psels) begin
        chk("paddrs", paddrs, cur.a);
        chk("pwrites", {31'd0, pwrites}, {31'd0, cur.w});
        if (cur.w) chk("pwdatas", pwdatas, cur.d);
      end
    end
    acc_idx = (psels && penables) ? acc_idx + 1 : 0;
    preadys = (psels && penables) ? (acc_idx == cur_ready) : 1'($urandom_range(0, 1));
    prdatas = (psels && penables && acc_idx >= 2) ? sensor_rd(sens, paddrs) : 32'hDEAD_BEEF;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input int r);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_ready_at = r; cmd_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_accept && n < 200);
    if (!last_accept) chk("send_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || psels) && n < 3000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || psels) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_t vt[11];
    int   gaps, n;
    logic got;
    vt[0]  = '{1'b1, 32'h01, 32'h20,        3,  1'b0, 32'h0,         3};
    vt[1]  = '{1'b0, 32'h01, 32'h0,         1,  1'b0, 32'h20,        2};
    vt[2]  = '{1'b1, 32'h0C, 32'h1F4,       1,  1'b0, 32'h0,         1};
    vt[3]  = '{1'b0, 32'h0C, 32'h0,         7,  1'b0, 32'h1F4,       2};
    vt[4]  = '{1'b1, 32'h0A, 32'hCAFE,      0,  1'b1, 32'h0,         16};
    vt[5]  = '{1'b0, 32'h0A, 32'h0,         0,  1'b0, 32'h0,         2};
    vt[6]  = '{1'b1, 32'h0A, 32'h55,        16, 1'b0, 32'h0,         16};
    vt[7]  = '{1'b1, 32'h0B, 32'h66,        17, 1'b1, 32'h0,         16};
    vt[8]  = '{1'b0, 32'h0A, 32'h0,         2,  1'b0, 32'h55,        2};
    vt[9]  = '{1'b0, 32'h0B, 32'h0,         1,  1'b0, 32'h0,         2};
    vt[10] = '{1'b0, 32'h20, 32'h0,         1,  1'b0, 32'hA5A5_0020, 2};

    presets = 1'b1;
    repeat (3) tick();
    chk("rst_pwrites", {31'd0, pwrites}, 32'd0);
    chk("rst_paddrs", paddrs, 32'd0);
    chk("rst_pwdatas", pwdatas, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    presets = 1'b0;
    tick();

    // Issue latency: SETUP after one edge, ACCESS after two
    send(1'b1, 32'h03, 32'h5, 2);
    chk("lat_idle", {31'd0, psels}, 32'd0);
    tick();
    chk("lat_setup", {30'd0, psels, penables}, 32'd2);
    tick();
    chk("lat_access", {30'd0, psels, penables}, 32'd3);
    drain();

    for (int i = 0; i < 11; i++) begin
      send(vt[i].w, vt[i].a, vt[i].d, vt[i].r);
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
        tick();
        got = rsp_valid;
      end
      chk("vec_rsp_seen", {31'd0, got}, 32'd1);
      chk("vec_err", {31'd0, rsp_err}, {31'd0, vt[i].err});
      chk("vec_rdata", rsp_rdata, vt[i].rdata);
      chk("vec_len", 32'(last_len), 32'(vt[i].len));
      chk("vec_psels_after", {31'd0, psels}, 32'd0);
    end

    // Five back-to-back writes: FIFO fills, no idle gap, 4 cycles per transfer
    for (int i = 0; i < 5; i++) send(1'b1, 32'h08, 32'h11 + 32'(i), 3);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    gaps = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
      if (!psels && exp_q.size() != 0) gaps++;
    end
    chk("b2b_gaps", 32'(gaps), 32'd0);
    chk("b2b_cycles", 32'(n), 32'd17);
    chk("b2b_last_write", sens.regs[8], 32'h15);
    drain();

    // Timeout followed by a normally completing queued write
    send(1'b1, 32'h0D, 32'hBAD, 0);
    send(1'b1, 32'h0E, 32'h77, 2);
    drain();
    chk("to_reg_untouched", sens.regs[13], 32'h0);
    chk("to_next_write", sens.regs[14], 32'h77);

    // Reset during ACCESS with two commands queued
    send(1'b1, 32'h0F, 32'h99, 0);
    send(1'b1, 32'h08, 32'h1, 1);
    send(1'b1, 32'h08, 32'h2, 1);
    chk("mid_in_access", {30'd0, psels, penables}, 32'd3);
    presets = 1'b1;
    tick();
    presets = 1'b0;
    gaps = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (psels || rsp_valid) gaps++;
    end
    chk("mid_flushed", 32'(gaps), 32'd0);
    chk("mid_no_write", sens.regs[15], 32'h0);
    chk("mid_reg8_kept", sens.regs[8], 32'h15);

    // Navigation sequencer programming of the sun sensor
    send(1'b1, 32'h01, 32'h10, 1);
    send(1'b1, 32'h02, 32'h04, 1);
    send(1'b1, 32'h00, 32'h01, 1);
    send(1'b1, 32'h04, 32'h30, 1);
    send(1'b1, 32'h04, 32'h05, 1);
    send(1'b1, 32'h04, 32'h40, 1);
    send(1'b1, 32'h04, 32'h12, 1);
    send(1'b0, 32'h06, 32'h0, 1);
    drain();
    chk("sensor_sum", rsp_rdata, 32'h82);
    chk("sensor_err", {31'd0, rsp_err}, 32'd0);

    // Random traffic with idle gaps, varied ready delays and timeouts
    for (int i = 0; i < 200; i++) begin
      int r, sel;
      logic w;
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0 && !w) ? 32'h06 : 32'(8 + $urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0) r = 0;
      else if (sel == 1) r = TIMEOUT + $urandom_range(1, 3);
      else r = $urandom_range(1, 4);
      send(w, a, $urandom, r);
    end
    drain();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
